// File: rtl/julia_pkg.sv
// Shared types and fixed-point helpers for the Julia frame engine.
// Pure definitions: no latency, no flow control.
package julia_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ITER,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  // Bit of the pixel word marking a pixel that never escaped.
  localparam int INSIDE_FLAG = 31;

  localparam int ESCAPE_MAG = 4;

  // |z|^2 escape threshold expressed at the 2*FRAC_W product scale.
  function automatic logic signed [63:0] escape_r2(input int frac_w);
    return 64'(ESCAPE_MAG) <<< (2 * frac_w);
  endfunction

  // Clamp v to the signed range of a w-bit word (w <= 63).
  function automatic logic signed [63:0] sat_s64(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/julia_iter_core.sv
// One z <- z^2 + c step plus the escape test; purely combinational.
// Zero latency, no flow control (the caller decides when to register zr_n/zi_n).
module julia_iter_core
  import julia_pkg::*;
#(
  parameter int DATA_W = 22,
  parameter int FRAC_W = 10
) (
  input  logic signed [DATA_W-1:0] zr,
  input  logic signed [DATA_W-1:0] zi,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] zr_n,
  output logic signed [DATA_W-1:0] zi_n,
  output logic                     escape
);

  localparam int P2 = 2 * DATA_W;
  localparam logic signed [P2:0] ESCAPE_R2 = (P2 + 1)'(escape_r2(FRAC_W));

  logic signed [P2-1:0]   zr2;
  logic signed [P2-1:0]   zi2;
  logic signed [P2-1:0]   zrzi;
  logic signed [P2:0]     mag;
  logic signed [P2:0]     diff;
  logic signed [P2+1:0]   cross2;
  logic signed [DATA_W-1:0] re_s;
  logic signed [DATA_W-1:0] im_s;

  assign zr2  = zr * zr;
  assign zi2  = zi * zi;
  assign zrzi = zr * zi;

  // Sum and difference are kept one bit wider than the products so nothing wraps.
  assign mag    = (P2 + 1)'(zr2) + (P2 + 1)'(zi2);
  assign diff   = (P2 + 1)'(zr2) - (P2 + 1)'(zi2);
  assign cross2 = (P2 + 2)'(zrzi) <<< 1;
  assign escape = mag > ESCAPE_R2;

  assign re_s = DATA_W'(sat_s64(64'(diff >>> FRAC_W), DATA_W));
  assign im_s = DATA_W'(sat_s64(64'(cross2 >>> FRAC_W), DATA_W));

  assign zr_n = re_s + a;
  assign zi_n = im_s + b;

endmodule

// File: rtl/julia_frame_engine.sv
// Raster-scans a Julia frame, one iteration per cycle, one write per pixel.
// Per pixel: INIT + (count+1) ITER cycles; WRITE holds addr/data until wr_done.
module julia_frame_engine
  import julia_pkg::*;
#(
  parameter int              DATA_W    = 22,
  parameter int              FRAC_W    = 10,
  parameter int              H_RES     = 640,
  parameter int              V_RES     = 480,
  parameter int              MAX_ITER  = 255,
  parameter int              ADDR_W    = 32,
  parameter longint unsigned BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_sig,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] x_start,
  input  logic signed [DATA_W-1:0] y_start,
  input  logic signed [DATA_W-1:0] step,
  output logic                     wr_ready,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [31:0]              wr_data,
  input  logic                     wr_done,
  output logic                     busy,
  output logic                     frame_done
);

  state_t state_q, state_d;
  logic signed [DATA_W-1:0] a_q, a_d, b_q, b_d, xs_q, xs_d, step_q, step_d;
  logic signed [DATA_W-1:0] cx_q, cx_d, cy_q, cy_d, zr_q, zr_d, zi_q, zi_d;
  logic [15:0]              px_q, px_d, py_q, py_d, iter_q, iter_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [31:0]              data_q, data_d;
  logic signed [DATA_W-1:0] zr_n, zi_n;
  logic                     escape;

  julia_iter_core #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_core (
    .zr     (zr_q),
    .zi     (zi_q),
    .a      (a_q),
    .b      (b_q),
    .zr_n   (zr_n),
    .zi_n   (zi_n),
    .escape (escape)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      xs_q    <= '0;
      step_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      zr_q    <= '0;
      zi_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      iter_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      xs_q    <= xs_d;
      step_q  <= step_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
      px_q    <= px_d;
      py_q    <= py_d;
      iter_q  <= iter_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    xs_d    = xs_q;
    step_d  = step_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    px_d    = px_q;
    py_d    = py_q;
    iter_d  = iter_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start_sig) begin
          a_d     = a;
          b_d     = b;
          xs_d    = x_start;
          step_d  = step;
          cx_d    = x_start;
          cy_d    = y_start;
          px_d    = '0;
          py_d    = '0;
          addr_d  = ADDR_W'(BASE_ADDR);
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        zr_d    = cx_q;
        zi_d    = cy_q;
        iter_d  = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (escape) begin
          data_d  = {16'h0000, iter_q};
          state_d = S_WRITE;
        end else if (iter_q == 16'(MAX_ITER)) begin
          data_d              = {16'h0000, iter_q};
          data_d[INSIDE_FLAG] = 1'b1;
          state_d             = S_WRITE;
        end else begin
          zr_d   = zr_n;
          zi_d   = zi_n;
          iter_d = iter_q + 16'd1;
        end
      end
      S_WRITE: begin
        if (wr_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        addr_d = addr_q + ADDR_W'(4);
        if (px_q < 16'(H_RES - 1)) begin
          px_d = px_q + 16'd1;
          cx_d = cx_q + step_q;
        end else begin
          px_d = '0;
          cx_d = xs_q;
          py_d = py_q + 16'd1;
          cy_d = cy_q - step_q;
        end
        // px/py still name the pixel that was just written.
        if (px_q == 16'(H_RES - 1) && py_q == 16'(V_RES - 1)) state_d = S_DONE;
        else                                                  state_d = S_INIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_ready   = (state_q == S_WRITE);
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_julia_frame_engine.sv
// Directed and randomized frames against an arithmetic reference of the Julia raster.
module tb_julia_frame_engine;

  localparam int          DW   = 22;
  localparam int          FW   = 10;
  localparam int          HR   = 4;
  localparam int          VR   = 2;
  localparam int          MI   = 15;
  localparam logic [31:0] BASE = 32'h1000;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start_sig = 1'b0;
  logic signed [DW-1:0] a = '0, b = '0, x_start = '0, y_start = '0, step = '0;
  logic                 wr_ready;
  logic [31:0]          wr_addr;
  logic [31:0]          wr_data;
  logic                 wr_done = 1'b0;
  logic                 busy;
  logic                 frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;

  julia_frame_engine #(
    .DATA_W(DW), .FRAC_W(FW), .H_RES(HR), .V_RES(VR),
    .MAX_ITER(MI), .ADDR_W(32), .BASE_ADDR(64'h1000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_sig  (start_sig),
    .a          (a),
    .b          (b),
    .x_start    (x_start),
    .y_start    (y_start),
    .step       (step),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_done    (wr_done),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint wrap_w(input longint v);
    logic signed [DW-1:0] t;
    t = v[DW-1:0];
    return longint'(t);
  endfunction

  function automatic longint sat_w(input longint v);
    longint hi;
    hi = (longint'(1) << (DW - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  // Pixel word for a starting point z0 and constant c, straight from the iteration rule.
  function automatic logic [31:0] ref_pixel(input longint zr0, input longint zi0,
                                            input longint ca, input longint cb);
    longint zr, zi, nr, ni;
    zr = zr0;
    zi = zi0;
    for (int it = 0; it <= MI; it++) begin
      if (zr * zr + zi * zi > (longint'(4) << (2 * FW))) return 32'(it);
      if (it == MI) return 32'h8000_0000 | 32'(it);
      nr = sat_w((zr * zr - zi * zi) >>> FW) + ca;
      ni = sat_w((2 * zr * zi) >>> FW) + cb;
      zr = wrap_w(nr);
      zi = wrap_w(ni);
    end
    return 32'hFFFF_FFFF;
  endfunction

  function automatic longint rnd_s(input int span);
    return longint'($urandom_range(0, 2 * span - 1)) - longint'(span);
  endfunction

  task automatic run_frame(input longint ca, input longint cb, input longint xs,
                           input longint ys, input longint st, input int hold,
                           input bit disturb);
    logic [31:0] exp_d;
    int gap, fd0, px, py;
    bit ok;
    fd0 = fd_cnt;
    @(negedge clk);
    a = DW'(ca); b = DW'(cb); x_start = DW'(xs); y_start = DW'(ys); step = DW'(st);
    start_sig = 1'b1;
    @(negedge clk);
    start_sig = 1'b0;
    gap = 0;
    if (disturb) begin
      a = DW'(rnd_s(2048)); b = DW'(rnd_s(2048));
      x_start = DW'(rnd_s(2048)); y_start = DW'(rnd_s(2048)); step = DW'(rnd_s(256));
    end
    for (int p = 0; p < HR * VR; p++) begin
      px = p % HR;
      py = p / HR;
      exp_d = ref_pixel(wrap_w(xs + px * st), wrap_w(ys - py * st), ca, cb);
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
        if (wr_ready === 1'b1) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
        gap++;
      end
      if (!ok) begin
        chk("wr_ready_timeout", 64'd0, 64'd1);
        return;
      end
      chk("iter_cycles", 64'(gap), 64'(exp_d[15:0]) + ((p == 0) ? 64'd2 : 64'd3));
      chk("wr_addr", 64'(wr_addr), 64'(BASE) + 64'(4 * p));
      chk("wr_data", 64'(wr_data), 64'(exp_d));
      for (int h = 0; h < hold; h++) begin
        if (disturb && p == 2 && h == 0) start_sig = 1'b1;
        @(negedge clk);
        start_sig = 1'b0;
        chk("hold_ready", 64'(wr_ready), 64'd1);
        chk("hold_addr", 64'(wr_addr), 64'(BASE) + 64'(4 * p));
        chk("hold_data", 64'(wr_data), 64'(exp_d));
      end
      wr_done = 1'b1;
      @(negedge clk);
      wr_done = 1'b0;
      chk("wr_ready_drop", 64'(wr_ready), 64'd0);
      gap = 0;
    end
    @(negedge clk);
    chk("frame_done_hi", 64'(frame_done), 64'd1);
    chk("busy_in_done", 64'(busy), 64'd1);
    @(negedge clk);
    #1;
    chk("frame_done_lo", 64'(frame_done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("frame_done_pulses", 64'(fd_cnt - fd0), 64'd1);
  endtask

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    rst = 1'b0;

    // Inside set, known escape, immediate escape, backpressure, raster stepping.
    run_frame(0, 0, 0, 0, 0, 0, 1'b0);
    run_frame(1024, 0, 0, 0, 0, 0, 1'b0);
    run_frame(0, 0, 3072, 0, 0, 0, 1'b0);
    run_frame(1024, 0, 0, 0, 0, 5, 1'b0);
    run_frame(0, 0, 0, 0, 256, 0, 1'b0);
    run_frame(-410, 307, 0, 0, 256, 1, 1'b1);

    for (int r = 0; r < 4; r++) begin
      run_frame(rnd_s(2048), rnd_s(2048), rnd_s(2048), rnd_s(2048),
                longint'($urandom_range(0, 511)), int'($urandom_range(1, 3)), 1'b1);
    end

    // Reset while a write is pending, then a fresh frame.
    @(negedge clk);
    a = '0; b = '0; x_start = '0; y_start = '0; step = '0;
    start_sig = 1'b1;
    @(negedge clk);
    start_sig = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (wr_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("pre_reset_write", 64'(ok), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_wr_addr", 64'(wr_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(1024, 0, 0, 0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
